// File: rtl/pc_unit.sv
// Program-counter unit: sequential step, jump, call and return through a
// circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 4,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           stall,
  input  logic [1:0]                     op,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_PC_C = WIDTH'(RESET_PC);
  localparam logic [CW-1:0]    DEPTH_C    = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    wptr;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] ras_top;
  logic             adv;

  assign adv       = en & ~stall;
  assign seq       = pc + STEP_C;
  assign ras_top   = ras_mem[wptr - 1'b1];
  assign ras_full  = (ras_count == DEPTH_C);
  assign ras_empty = (ras_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC_C;
      wptr      <= '0;
      ras_count <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else if (adv) begin
      case (op)
        OP_SEQ:  pc <= seq;
        OP_JUMP: pc <= target;
        OP_CALL: begin
          pc   <= target;
          wptr <= wptr + 1'b1;
          // when full the push lands on the oldest slot, so depth stays put
          if (ras_full) err_ovf   <= 1'b1;
          else          ras_count <= ras_count + 1'b1;
        end
        default: begin
          if (ras_empty) begin
            pc      <= seq;
            err_unf <= 1'b1;
          end else begin
            pc        <= ras_top;
            wptr      <= wptr - 1'b1;
            ras_count <= ras_count - 1'b1;
          end
        end
      endcase
    end
  end

  // stack contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (adv && op == OP_CALL) ras_mem[wptr] <= seq;
  end

endmodule
